// File: rtl/fetch_pc_controller.sv
// Fetch-stage PC sequencer: sequential fetch, EX redirects, load-use stalls, I-cache miss wait.
// Optional FETCH_PERF_CNT_EN adds saturating fetch / miss / miss-cycle counters.
module fetch_pc_controller #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PC_STEP = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            icache_req_o,
  output logic [XLEN-1:0] icache_addr_o,
  input  logic            icache_ready_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            pc_en_o,
  output logic            fetch_valid_o,
  output logic            flush_if_id_o,
  output logic            miss_state_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_fetch_cnt_o,
  output logic [CNT_W-1:0] perf_miss_cnt_o,
  output logic [CNT_W-1:0] perf_miss_cyc_o
`endif
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);

  typedef enum logic {RUN = 1'b0, WAIT_MEM = 1'b1} state_t;

  state_t          state, state_d;
  logic            redirect_pend, pend_d;
  logic [XLEN-1:0] pend_target, target_d;
  logic [XLEN-1:0] miss_addr, miss_addr_d;

  logic            req_c, en_c, fv_c, flush_c;
  logic [XLEN-1:0] addr_c, next_c;
  logic [XLEN-1:0] br_aligned;

  assign br_aligned = branch_target_i & ALIGN_MASK;

  // State, pending-redirect and miss-address registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= RUN;
      redirect_pend <= 1'b0;
      pend_target   <= '0;
      miss_addr     <= '0;
    end else begin
      state         <= state_d;
      redirect_pend <= pend_d;
      pend_target   <= target_d;
      miss_addr     <= miss_addr_d;
    end
  end

  // Next-state and combinational outputs
  always_comb begin
    state_d     = state;
    pend_d      = redirect_pend;
    target_d    = pend_target;
    miss_addr_d = miss_addr;
    req_c       = 1'b0;
    addr_c      = '0;
    en_c        = 1'b0;
    next_c      = '0;
    fv_c        = 1'b0;
    flush_c     = 1'b0;
    case (state)
      RUN: begin
        req_c  = 1'b1;
        addr_c = pc_i & ALIGN_MASK;
        if (branch_taken_i) begin
          en_c    = 1'b1;
          next_c  = br_aligned;
          flush_c = 1'b1;
        end else if (stall_i) begin
          en_c = 1'b0;
        end else if (icache_ready_i) begin
          en_c   = 1'b1;
          next_c = pc_i + STEP;
          fv_c   = 1'b1;
        end else begin
          miss_addr_d = addr_c;
          state_d     = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        req_c  = 1'b1;
        addr_c = miss_addr;
        // Youngest redirect wins; it is applied once the miss completes
        if (branch_taken_i) begin
          flush_c  = 1'b1;
          pend_d   = 1'b1;
          target_d = br_aligned;
        end
        if (icache_ready_i) begin
          state_d = RUN;
          if (branch_taken_i || redirect_pend) begin
            en_c   = 1'b1;
            next_c = branch_taken_i ? br_aligned : pend_target;
            pend_d = 1'b0;
          end else if (!stall_i) begin
            en_c   = 1'b1;
            next_c = miss_addr + STEP;
            fv_c   = 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign icache_req_o  = rst & req_c;
  assign icache_addr_o = rst ? addr_c : '0;
  assign pc_en_o       = rst & en_c;
  assign pc_next_o     = rst ? next_c : '0;
  assign fetch_valid_o = rst & fv_c;
  assign flush_if_id_o = rst & flush_c;
  assign miss_state_o  = rst & (state == WAIT_MEM);

`ifdef FETCH_PERF_CNT_EN
  // Saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt_o <= '0;
      perf_miss_cnt_o  <= '0;
      perf_miss_cyc_o  <= '0;
    end else begin
      if (fv_c && perf_fetch_cnt_o != '1)
        perf_fetch_cnt_o <= perf_fetch_cnt_o + CNT_W'(1);
      if (state == RUN && state_d == WAIT_MEM && perf_miss_cnt_o != '1)
        perf_miss_cnt_o <= perf_miss_cnt_o + CNT_W'(1);
      if (state == WAIT_MEM && perf_miss_cyc_o != '1)
        perf_miss_cyc_o <= perf_miss_cyc_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_controller.sv
// Bench for fetch_pc_controller: transaction-level reference model plus directed vectors.
// Acts as the PC register (loads pc_next_o when pc_en_o) between directed pc_i overrides.
module tb_fetch_pc_controller;

  localparam int unsigned CNT_MAX = 65535;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, branch_target_i, icache_addr_o, pc_next_o;
  logic        stall_i, branch_taken_i, icache_ready_i;
  logic        icache_req_o, pc_en_o, fetch_valid_o, flush_if_id_o, miss_state_o;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt_o, perf_miss_cnt_o, perf_miss_cyc_o;
`endif

  int n_chk = 0;
  int n_fail = 0;

  fetch_pc_controller dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .stall_i(stall_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .icache_req_o(icache_req_o), .icache_addr_o(icache_addr_o),
    .icache_ready_i(icache_ready_i), .pc_next_o(pc_next_o), .pc_en_o(pc_en_o),
    .fetch_valid_o(fetch_valid_o), .flush_if_id_o(flush_if_id_o),
    .miss_state_o(miss_state_o)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt_o(perf_fetch_cnt_o), .perf_miss_cnt_o(perf_miss_cnt_o),
    .perf_miss_cyc_o(perf_miss_cyc_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of outstanding miss addresses (empty = running) and
  // queue of redirect targets seen while waiting (last one is the youngest).
  logic [31:0] missq[$];
  logic [31:0] tgtq[$];
  int m_fetch = 0, m_miss = 0, m_cyc = 0;

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  initial begin
    logic        e_req, e_en, e_fv, e_fl, e_ms, push, pop, waiting;
    logic [31:0] e_addr, e_next, act_next;
    forever begin
      @(negedge clk);
      {e_req, e_en, e_fv, e_fl, e_ms, push, pop} = '0;
      e_addr  = '0;
      e_next  = '0;
      waiting = (missq.size() != 0);
      if (rst) begin
        e_req = 1'b1;
        if (!waiting) begin
          e_addr = pc_i & ~32'h3;
          if (branch_taken_i) begin
            e_en = 1'b1; e_next = branch_target_i & ~32'h3; e_fl = 1'b1;
          end else if (!stall_i && icache_ready_i) begin
            e_en = 1'b1; e_next = pc_i + 32'd4; e_fv = 1'b1;
          end else if (!stall_i) begin
            push = 1'b1;
          end
        end else begin
          e_ms   = 1'b1;
          e_addr = missq[0];
          e_fl   = branch_taken_i;
          if (icache_ready_i) begin
            pop = 1'b1;
            if (branch_taken_i) begin
              e_en = 1'b1; e_next = branch_target_i & ~32'h3;
            end else if (tgtq.size() != 0) begin
              e_en = 1'b1; e_next = tgtq[$];
            end else if (!stall_i) begin
              e_en = 1'b1; e_next = missq[0] + 32'd4; e_fv = 1'b1;
            end
          end
        end
      end
      act_next = (e_en || !rst) ? pc_next_o : 32'h0;
      chk("cycle", {11'h0, icache_req_o, icache_addr_o, pc_en_o, act_next,
                    fetch_valid_o, flush_if_id_o, miss_state_o},
                   {11'h0, e_req, e_addr, e_en, e_next, e_fv, e_fl, e_ms});
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch", 80'(perf_fetch_cnt_o), 80'(m_fetch));
      chk("perf_miss", 80'(perf_miss_cnt_o), 80'(m_miss));
      chk("perf_miss_cyc", 80'(perf_miss_cyc_o), 80'(m_cyc));
`endif
      @(posedge clk);
      if (!rst) begin
        missq.delete(); tgtq.delete();
        m_fetch = 0; m_miss = 0; m_cyc = 0;
      end else begin
        if (waiting && branch_taken_i && !pop) tgtq.push_back(branch_target_i & ~32'h3);
        if (pop) begin missq.pop_front(); tgtq.delete(); end
        if (push) missq.push_back(e_addr);
        if (e_fv) m_fetch = sat(m_fetch);
        if (push) m_miss = sat(m_miss);
        if (waiting) m_cyc = sat(m_cyc);
      end
    end
  end

  // One clock: capture outputs mid-cycle, then act as the PC register.
  logic        c_req, c_en, c_fv, c_fl, c_ms;
  logic [31:0] c_addr, c_next;
  task automatic cyc();
    @(negedge clk);
    {c_req, c_en, c_fv, c_fl, c_ms} = {icache_req_o, pc_en_o, fetch_valid_o, flush_if_id_o, miss_state_o};
    c_addr = icache_addr_o;
    c_next = pc_next_o;
    @(posedge clk);
    #1;
    if (c_en && rst) pc_i = c_next;
  endtask

  initial begin
    rst = 1'b0; pc_i = '0; stall_i = 1'b0; branch_taken_i = 1'b0;
    branch_target_i = '0; icache_ready_i = 1'b1;
    cyc(); cyc();
    chk("reset_outputs", 80'({c_req, c_en, c_fv, c_fl, c_ms, c_addr, c_next}), 80'(0));
    rst = 1'b1;

    // Sequential hits from 0
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("seq_addr", 80'(c_addr), 80'(i * 4));
      chk("seq_en_fv", 80'({c_en, c_fv}), 80'(2'b11));
    end

    // Miss on 0x100, three idle wait cycles, then completion
    pc_i = 32'h100; icache_ready_i = 1'b0;
    cyc();
    chk("miss_enter", 80'({c_ms, c_en, c_addr}), {47'h0, 1'b0, 1'b0, 32'h100});
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("miss_hold", 80'({c_ms, c_en, c_req, c_addr}), {46'h0, 1'b1, 1'b0, 1'b1, 32'h100});
    end
    icache_ready_i = 1'b1;
    cyc();
    chk("miss_done", 80'({c_en, c_fv, c_next}), {46'h0, 1'b1, 1'b1, 32'h104});
    cyc();
    chk("miss_exit", 80'({c_ms, c_addr}), {47'h0, 1'b0, 32'h104});

    // Load-use stall for two cycles with ready high
    pc_i = 32'h20; stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("stall", 80'({c_en, c_fv, c_addr}), {46'h0, 1'b0, 1'b0, 32'h20});
    end
    stall_i = 1'b0;
    cyc();
    chk("stall_release", 80'({c_en, c_next}), {47'h0, 1'b1, 32'h24});

    // Redirect during a miss is held until the miss completes
    pc_i = 32'h200; icache_ready_i = 1'b0;
    cyc();
    branch_taken_i = 1'b1; branch_target_i = 32'h403;
    cyc();
    chk("wait_flush", 80'({c_fl, c_ms, c_en}), 80'(3'b110));
    branch_taken_i = 1'b0;
    cyc();
    chk("wait_noflush", 80'(c_fl), 80'(0));
    icache_ready_i = 1'b1;
    cyc();
    chk("pend_redirect", 80'({c_en, c_fv, c_next}), {46'h0, 1'b1, 1'b0, 32'h400});

    // Two redirects while waiting: the youngest target is used
    icache_ready_i = 1'b0;
    cyc();
    branch_taken_i = 1'b1; branch_target_i = 32'h500;
    cyc();
    branch_target_i = 32'h606;
    cyc();
    branch_taken_i = 1'b0; icache_ready_i = 1'b1;
    cyc();
    chk("youngest_wins", 80'({c_en, c_fv, c_next}), {46'h0, 1'b1, 1'b0, 32'h604});

    // Miss completes under stall: no update, then re-fetch hits
    icache_ready_i = 1'b0;
    cyc();
    stall_i = 1'b1; icache_ready_i = 1'b1;
    cyc();
    chk("wait_stall", 80'({c_en, c_fv, c_ms}), 80'(3'b001));
    stall_i = 1'b0;
    cyc();
    chk("refetch", 80'({c_ms, c_en, c_next}), {46'h0, 1'b0, 1'b1, 32'h608});

    // Redirect in the same cycle the miss completes
    icache_ready_i = 1'b0;
    cyc();
    branch_taken_i = 1'b1; branch_target_i = 32'h700; icache_ready_i = 1'b1;
    cyc();
    chk("wait_br_ready", 80'({c_en, c_fv, c_fl, c_next}), {45'h0, 1'b1, 1'b0, 1'b1, 32'h700});

    // Redirect beats stall in RUN
    stall_i = 1'b1; branch_target_i = 32'h80;
    cyc();
    chk("br_over_stall", 80'({c_en, c_fv, c_fl, c_next}), {45'h0, 1'b1, 1'b0, 1'b1, 32'h80});
    branch_taken_i = 1'b0; stall_i = 1'b0;

    // PC increment wraps at the top of the address space
    pc_i = 32'hFFFF_FFFC;
    cyc();
    chk("wrap", 80'({c_en, c_fv, c_next}), {46'h0, 1'b1, 1'b1, 32'h0});

    // Asynchronous reset in the middle of a miss
    pc_i = 32'h300; icache_ready_i = 1'b0;
    cyc();
    branch_taken_i = 1'b1; branch_target_i = 32'h900;
    cyc();
    branch_taken_i = 1'b0;
    chk("pre_reset_wait", 80'(c_ms), 80'(1));
    #3 rst = 1'b0;
    #1;
    chk("async_reset", 80'({icache_req_o, pc_en_o, fetch_valid_o, flush_if_id_o, miss_state_o,
                            icache_addr_o, pc_next_o}), 80'(0));
`ifdef FETCH_PERF_CNT_EN
    chk("perf_reset", 80'({perf_fetch_cnt_o, perf_miss_cnt_o, perf_miss_cyc_o}), 80'(0));
`endif
    cyc(); cyc();
    rst = 1'b1; icache_ready_i = 1'b1; pc_i = 32'h300;
    cyc();
    chk("post_reset", 80'({c_ms, c_en, c_fv, c_next}), {45'h0, 1'b0, 1'b1, 1'b1, 32'h304});
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
